// File: rtl/sensemi_rst_pkg.sv
// Shared types and sizing helpers for the sensemi reset sequencer.
package sensemi_rst_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        HOLD    = ST_HOLD,
        RELEASE = ST_RELEASE,
        RUN     = ST_RUN
    } state_e;

    // One spare bit above $clog2 so a counter can hold its own limit value.
    function automatic int cnt_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/sensemi_sync_cell.sv
// Multi-flop synchroniser with asynchronous active-low clear.
module sensemi_sync_cell #(
    parameter int STAGES = 3
) (
    input  logic i_clk,
    input  logic i_clr_n,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/sensemi_rst_seq.sv
// Reset sequencer: synchronises reset/lock, releases channel resets in a
// staggered order, handles per-channel soft resets and drives a heartbeat.
module sensemi_rst_seq
    import sensemi_rst_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int SYNC_STAGES     = 3,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGGER_CYCLES  = 8,
    parameter int SOFT_RST_CYCLES = 4,
    parameter int HB_DIV          = 25000000
) (
    input  logic              i_fpga_clk,
    input  logic              i_fpga_rst_n,
    input  logic              i_locked,
    input  logic [NUM_CH-1:0] i_soft_rst_req,
    output logic [NUM_CH-1:0] o_rst_n,
    output logic              o_all_ready,
    output logic              o_heartbeat,
    output logic [1:0]        o_state
);

    localparam int CNT_LIM = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = cnt_width(CNT_LIM);
    localparam int IDX_W   = cnt_width(NUM_CH);
    localparam int SOFT_W  = cnt_width(SOFT_RST_CYCLES);
    localparam int HB_W    = cnt_width(HB_DIV);

    logic w_rst_sync_n;
    logic w_locked_s;

    sensemi_sync_cell #(.STAGES(SYNC_STAGES)) u_rst_sync (
        .i_clk   (i_fpga_clk),
        .i_clr_n (i_fpga_rst_n),
        .i_d     (1'b1),
        .o_q     (w_rst_sync_n)
    );

    // Lock chain is held clear until the internal reset has been released.
    sensemi_sync_cell #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .i_clk   (i_fpga_clk),
        .i_clr_n (w_rst_sync_n),
        .i_d     (i_locked),
        .o_q     (w_locked_s)
    );

    state_e             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [IDX_W-1:0]   r_idx, w_idx_next;
    logic [NUM_CH-1:0]  r_rst_n;
    logic               r_all_ready;
    logic [HB_W-1:0]    r_hb_cnt;
    logic               r_heartbeat;
    logic [NUM_CH-1:0]  w_rel_next;
    logic [NUM_CH-1:0]  w_soft_busy_next;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        unique case (r_state)
            IDLE: begin
                if (w_locked_s) begin
                    w_state_next = HOLD;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                end
            end
            HOLD: begin
                if (!w_locked_s) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    w_state_next = RELEASE;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (!w_locked_s) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                end else if (r_idx == IDX_W'(NUM_CH - 1)) begin
                    w_state_next = RUN;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
                    w_idx_next = r_idx + IDX_W'(1);
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!w_locked_s) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
                w_idx_next   = '0;
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [SOFT_W-1:0] r_soft;
        logic [SOFT_W-1:0] w_soft_next;

        // Leaving RUN (lock loss) wipes any soft reset in progress.
        always_comb begin
            w_soft_next = r_soft;
            if (w_state_next != RUN) begin
                w_soft_next = '0;
            end else if ((r_state == RUN) && i_soft_rst_req[gi]) begin
                w_soft_next = SOFT_W'(SOFT_RST_CYCLES);
            end else if (r_soft != '0) begin
                w_soft_next = r_soft - SOFT_W'(1);
            end
        end

        always_ff @(posedge i_fpga_clk or negedge w_rst_sync_n) begin
            if (!w_rst_sync_n) begin
                r_soft <= '0;
            end else begin
                r_soft <= w_soft_next;
            end
        end

        assign w_soft_busy_next[gi] = (w_soft_next != '0);
        assign w_rel_next[gi]       = (w_state_next == RUN) ||
                                      ((w_state_next == RELEASE) && (IDX_W'(gi) <= w_idx_next));
    end

    always_ff @(posedge i_fpga_clk or negedge w_rst_sync_n) begin
        if (!w_rst_sync_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_rst_n     <= '0;
            r_all_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_idx       <= w_idx_next;
            r_rst_n     <= w_rel_next & ~w_soft_busy_next;
            r_all_ready <= (w_state_next == RUN) && (w_soft_busy_next == '0);
        end
    end

    always_ff @(posedge i_fpga_clk or negedge w_rst_sync_n) begin
        if (!w_rst_sync_n) begin
            r_hb_cnt    <= '0;
            r_heartbeat <= 1'b0;
        end else if (r_hb_cnt == HB_W'(HB_DIV - 1)) begin
            r_hb_cnt    <= '0;
            r_heartbeat <= ~r_heartbeat;
        end else begin
            r_hb_cnt <= r_hb_cnt + HB_W'(1);
        end
    end

    assign o_rst_n     = r_rst_n;
    assign o_all_ready = r_all_ready;
    assign o_heartbeat = r_heartbeat;
    assign o_state     = r_state;

endmodule

// File: tb/tb_sensemi_rst_seq.sv
// Self-checking bench: directed phases plus random soft/lock stimulus, compared
// every cycle against a timestamp-based model of the sequencing rules.
module tb_sensemi_rst_seq;

    localparam int NUM_CH = 4;
    localparam int SS     = 3;
    localparam int HOLDC  = 16;
    localparam int STAG   = 8;
    localparam int SOFT   = 4;
    localparam int HB     = 10;
    localparam int MAXN   = 8192;

    logic              clk    = 1'b0;
    logic              rst_n  = 1'b0;
    logic              locked = 1'b1;
    logic [NUM_CH-1:0] req    = '0;
    logic [NUM_CH-1:0] rst_o;
    logic              ready;
    logic              hb;
    logic [1:0]        st;

    always #5 clk = ~clk;

    sensemi_rst_seq #(
        .NUM_CH(NUM_CH), .SYNC_STAGES(SS), .HOLD_CYCLES(HOLDC),
        .STAGGER_CYCLES(STAG), .SOFT_RST_CYCLES(SOFT), .HB_DIV(HB)
    ) dut (
        .i_fpga_clk     (clk),
        .i_fpga_rst_n   (rst_n),
        .i_locked       (locked),
        .i_soft_rst_req (req),
        .o_rst_n        (rst_o),
        .o_all_ready    (ready),
        .o_heartbeat    (hb),
        .o_state        (st)
    );

    // Model: edge count n, lock samples per edge, HOLD entry time, soft end times.
    int  n          = 0;
    int  since_rst  = 0;
    int  hb_edges   = 0;
    int  t_hold     = 0;
    bit  seq_on     = 1'b0;
    int  prev_state = 0;
    int  soft_end [NUM_CH];
    bit  lk [MAXN];
    int  tests = 0;
    int  fails = 0;

    logic [NUM_CH-1:0] exp_rst;
    logic              exp_ready;
    logic              exp_hb;
    logic [1:0]        exp_st;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, n, obs, expv);
        end
    endtask

    task automatic model_edge();
        bit ls;
        int e;
        int rel;
        bit soft_any;
        n++;
        if (n >= MAXN) $fatal(1, "FAIL edge_budget: observed %0d expected <%0d", n, MAXN);
        if (!rst_n) begin
            since_rst = 0;
            hb_edges  = 0;
            seq_on    = 1'b0;
            lk[n]     = 1'b0;
            for (int k = 0; k < NUM_CH; k++) soft_end[k] = 0;
        end else begin
            since_rst++;
            if (since_rst > SS) begin
                ls    = (n - SS >= 1) ? lk[n - SS] : 1'b0;
                lk[n] = locked;
                hb_edges++;
                if (!seq_on) begin
                    if (ls) begin
                        seq_on = 1'b1;
                        t_hold = n;
                    end
                end else if (!ls) begin
                    seq_on = 1'b0;
                    for (int k = 0; k < NUM_CH; k++) soft_end[k] = 0;
                end else if (prev_state == 3) begin
                    for (int k = 0; k < NUM_CH; k++)
                        if (req[k]) soft_end[k] = n + SOFT;
                end
            end else begin
                lk[n] = 1'b0;
            end
        end

        exp_rst   = '0;
        exp_ready = 1'b0;
        exp_st    = 2'd0;
        soft_any  = 1'b0;
        if (seq_on) begin
            e   = n - t_hold;
            rel = 0;
            if (e < HOLDC) begin
                exp_st = 2'd1;
            end else begin
                rel = (e - HOLDC) / STAG + 1;
                if (rel > NUM_CH) rel = NUM_CH;
                exp_st = (e >= HOLDC + (NUM_CH - 1) * STAG + 1) ? 2'd3 : 2'd2;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (n < soft_end[k]) soft_any = 1'b1;
                exp_rst[k] = (k < rel) && !(n < soft_end[k]);
            end
            exp_ready = (exp_st == 2'd3) && !soft_any;
        end
        exp_hb     = ((hb_edges / HB) % 2) == 1;
        prev_state = int'(exp_st);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("rst_n", 32'(rst_o), 32'(exp_rst));
        chk("all_ready", 32'(ready), 32'(exp_ready));
        chk("heartbeat", 32'(hb), 32'(exp_hb));
        chk("state", 32'(st), 32'(exp_st));
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] r);
        req = r;
        step();
        req = '0;
    endtask

    initial begin
        for (int k = 0; k < NUM_CH; k++) soft_end[k] = 0;

        // Power-up with lock present
        rst_n = 1'b0; locked = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (70) step();

        // Soft reset on ch0/ch2, then a repeat on ch0 two cycles later
        pulse(4'b0101);
        step();
        pulse(4'b0001);
        repeat (8) step();

        // Random soft requests in RUN
        repeat (40) begin
            req = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
            step();
        end
        req = '0;
        repeat (6) step();

        // Lock loss from RUN, then restore and ignore a request in HOLD
        locked = 1'b0;
        repeat (10) step();
        locked = 1'b1;
        repeat (8) step();
        pulse(4'b1111);

        // Drop lock after ch1 has released
        for (int i = 0; i < 200 && exp_rst != 4'b0011; i++) step();
        chk("reach_ch1", 32'(rst_o), 32'(4'b0011));
        locked = 1'b0;
        repeat (8) step();
        locked = 1'b1;
        repeat (60) step();

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_n", 32'(rst_o), 32'(0));
        chk("async_ready", 32'(ready), 32'(0));
        chk("async_hb", 32'(hb), 32'(0));
        repeat (3) step();

        // Reset release without lock, lock arrives later
        locked = 1'b0;
        rst_n  = 1'b1;
        repeat (100) step();
        locked = 1'b1;
        repeat (60) step();

        // Random lock glitches mixed with soft requests
        repeat (400) begin
            if ($urandom_range(0, 59) == 0) locked = ~locked;
            req = ($urandom_range(0, 4) == 0) ? NUM_CH'($urandom) : '0;
            step();
        end
        req = '0;
        locked = 1'b1;
        repeat (60) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
